// File: rtl/fp_norm_sched.sv
`default_nettype none
// ============================================================================
// Module      : fp_norm_sched
// Description : Round-robin scheduler sharing one pipelined normalizer between
//               NREQ producers, tracking result ownership through its latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 128,
    parameter int TAGW = 6,
    parameter int LAT  = 8,
    localparam int IDW = $clog2(NREQ),
    localparam int ICW = $clog2(LAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DW-1:0]   din_i,
    input  logic [NREQ-1:0]      under_i,
    input  logic [NREQ*TAGW-1:0] tag_i,
    output logic [NREQ-1:0]      ack_o,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic                 norm_ce_o,
    output logic [DW-1:0]        norm_d_o,
    output logic                 norm_under_o,
    output logic                 res_v_o,
    output logic [IDW-1:0]       res_id_o,
    output logic [TAGW-1:0]      res_tag_o,
    output logic [ICW-1:0]       inflight_o,
    output logic                 idle_o
);

    localparam logic [IDW:0]   c_nreq = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] c_last = IDW'(NREQ - 1);

    logic [IDW-1:0]  r_ptr;
    logic [LAT-1:0]  r_v;
    logic [IDW-1:0]  r_id  [LAT];
    logic [TAGW-1:0] r_tag [LAT];
    logic [ICW-1:0]  r_inflight;

    logic [IDW-1:0]  w_scan [NREQ];
    logic [IDW-1:0]  w_win;
    logic            w_found;
    logic            w_grant;
    logic [TAGW-1:0] w_tag;

    // Scan order starting at the pointer, wrapped modulo NREQ.
    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_scan
            logic [IDW:0] w_sum;
            assign w_sum     = {1'b0, r_ptr} + (IDW + 1)'(g);
            assign w_scan[g] = (w_sum >= c_nreq) ? IDW'(w_sum - c_nreq) : IDW'(w_sum);
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_i[w_scan[i]]) begin
                w_found = 1'b1;
                w_win   = w_scan[i];
            end
        end
    end

    assign w_grant      = rst_n & ~stall_i & ~flush_i & w_found;
    assign w_tag        = tag_i[int'(w_win)*TAGW +: TAGW];
    assign ack_o        = w_grant ? (NREQ'(1) << w_win) : '0;
    assign norm_d_o     = w_grant ? din_i[int'(w_win)*DW +: DW] : '0;
    assign norm_under_o = w_grant & under_i[w_win];
    assign norm_ce_o    = ~stall_i;

    // Gating with ce ensures a result held by a stall is flagged only once.
    assign res_v_o      = rst_n & norm_ce_o & r_v[LAT-1];
    assign res_id_o     = r_id[LAT-1];
    assign res_tag_o    = r_tag[LAT-1];
    assign inflight_o   = r_inflight;
    assign idle_o       = (r_inflight == '0) & ~|req_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_win == c_last) ? '0 : w_win + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_v <= '0;
        end else if (norm_ce_o) begin
            r_v <= {r_v[LAT-2:0], w_grant};
        end
    end

    // Ownership payload only matters where its valid bit is set.
    always_ff @(posedge clk) begin
        if (norm_ce_o) begin
            r_id[0]  <= w_win;
            r_tag[0] <= w_tag;
            for (int i = 1; i < LAT; i++) begin
                r_id[i]  <= r_id[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_inflight <= '0;
        end else begin
            case ({w_grant, res_v_o})
                2'b10:   r_inflight <= r_inflight + ICW'(1);
                2'b01:   r_inflight <= r_inflight - ICW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule
`default_nettype wire
